// File: rtl/lane_paint_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lane_paint_fsm
// Description : Drum-pad lane painter FSM with per-lane colours, debounced
//               lane entry, idle timeout and a saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_paint_fsm #(
    parameter int LANES        = 5,
    parameter int COLOR_W      = 3,
    parameter int DEBOUNCE     = 2,
    parameter int IDLE_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       static_req,
    input  logic [LANES-1:0]           lane_pad,
    input  logic [COLOR_W-1:0]         color_band,
    input  logic [LANES*COLOR_W-1:0]   lane_color,
    input  logic                       hit_clr,
    output logic [COLOR_W-1:0]         color_res,
    output logic                       static_act,
    output logic [LANES-1:0]           lane_act,
    output logic                       hit_pulse,
    output logic [CNT_W-1:0]           hit_count
);

    localparam int c_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_DEB_W = $clog2(DEBOUNCE + 1);
    localparam int c_TO_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEBOUNCE);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PAINT  = 2'd1,
        S_STATIC = 2'd2,
        S_LANE   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_lane, w_lane_nxt, w_pad_idx;
    logic [c_DEB_W-1:0]   r_deb_cnt, w_deb_nxt, w_deb_run;
    logic [c_TO_W-1:0]    r_to_cnt, w_to_nxt;
    logic [LANES-1:0]     r_prev_pad;
    logic [CNT_W-1:0]     r_hit_cnt;
    logic                 r_hit_pulse;
    logic                 w_onehot, w_quiet, w_enter;
    logic [COLOR_W-1:0]   w_lane_col;
    logic [LANES-1:0]     w_lane_mask;

    assign w_onehot    = $onehot(lane_pad);
    assign w_quiet     = !start && !static_req && (lane_pad == '0);
    assign w_lane_mask = LANES'(1) << r_lane;

    always_comb begin
        w_pad_idx  = '0;
        w_lane_col = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_pad[i])
                w_pad_idx = c_IDX_W'(i);
            if (r_lane == c_IDX_W'(i))
                w_lane_col = lane_color[i*COLOR_W +: COLOR_W];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_deb_nxt   = '0;
        w_deb_run   = '0;
        w_to_nxt    = '0;
        w_enter     = 1'b0;
        color_res   = '0;
        static_act  = 1'b0;
        lane_act    = '0;
        case (r_state)
            S_IDLE: begin
                if (start && !static_req && (lane_pad == '0))
                    w_state_nxt = S_PAINT;
            end
            S_PAINT: begin
                color_res = '1;
                if (static_req) begin
                    w_state_nxt = S_STATIC;
                end else if (w_onehot) begin
                    // Run length includes the current cycle; a zero count means no prior run.
                    if ((r_deb_cnt != '0) && (lane_pad == r_prev_pad))
                        w_deb_run = r_deb_cnt + c_DEB_W'(1);
                    else
                        w_deb_run = c_DEB_W'(1);
                    if (w_deb_run >= c_DEB_MAX) begin
                        w_state_nxt = S_LANE;
                        w_lane_nxt  = w_pad_idx;
                        w_enter     = 1'b1;
                    end else begin
                        w_deb_nxt = w_deb_run;
                    end
                end else if (w_quiet && (IDLE_TIMEOUT != 0)) begin
                    if (r_to_cnt + c_TO_W'(1) == c_TO_MAX)
                        w_state_nxt = S_IDLE;
                    else
                        w_to_nxt = r_to_cnt + c_TO_W'(1);
                end
            end
            S_STATIC: begin
                color_res  = color_band;
                static_act = 1'b1;
                if (!(static_req && ((lane_pad == '0) || w_onehot)))
                    w_state_nxt = S_PAINT;
            end
            S_LANE: begin
                color_res = w_lane_col;
                lane_act  = w_lane_mask;
                if (!((lane_pad == w_lane_mask) && !static_req))
                    w_state_nxt = S_PAINT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_deb_cnt   <= '0;
            r_to_cnt    <= '0;
            r_prev_pad  <= '0;
            r_hit_cnt   <= '0;
            r_hit_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane      <= w_lane_nxt;
            r_deb_cnt   <= w_deb_nxt;
            r_to_cnt    <= w_to_nxt;
            r_prev_pad  <= lane_pad;
            r_hit_pulse <= w_enter;
            if (hit_clr)
                r_hit_cnt <= '0;
            else if (w_enter && (r_hit_cnt != c_CNT_MAX))
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign hit_pulse = r_hit_pulse;
    assign hit_count = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lane_paint_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_paint_fsm
// Description : Table-driven scoreboard bench for lane_paint_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_paint_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        static_req = 1'b0;
    logic        hit_clr = 1'b0;
    logic [4:0]  lane_pad = '0;
    logic [2:0]  color_band = 3'd6;
    logic [14:0] lane_color = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    logic [2:0]  color_res;
    logic        static_act;
    logic [4:0]  lane_act;
    logic        hit_pulse;
    logic [1:0]  hit_count;

    lane_paint_fsm #(
        .LANES(5), .COLOR_W(3), .DEBOUNCE(2), .IDLE_TIMEOUT(8), .CNT_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .static_req(static_req),
        .lane_pad(lane_pad), .color_band(color_band), .lane_color(lane_color),
        .hit_clr(hit_clr), .color_res(color_res), .static_act(static_act),
        .lane_act(lane_act), .hit_pulse(hit_pulse), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sr;
        logic [4:0] pad;
        logic       clr;
        logic [2:0] col;
        logic       sa;
        logic [4:0] la;
        logic       hp;
        logic [1:0] hc;
    } vec_t;

    vec_t        tbl[$];
    logic [11:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic void add(input logic st, input logic sr, input logic [4:0] pad,
                                input logic clr, input logic [2:0] col, input logic sa,
                                input logic [4:0] la, input logic hp, input logic [1:0] hc);
        vec_t v;
        v.st = st; v.sr = sr; v.pad = pad; v.clr = clr;
        v.col = col; v.sa = sa; v.la = la; v.hp = hp; v.hc = hc;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [11:0] exp);
        logic [11:0] act;
        act = {color_res, static_act, lane_act, hit_pulse, hit_count};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got col=%0d sa=%b la=%b hp=%b hc=%0d, expected col=%0d sa=%b la=%b hp=%b hc=%0d",
                     nm, act[11:9], act[8], act[7:3], act[2], act[1:0],
                     exp[11:9], exp[8], exp[7:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        logic [11:0] exp;
        @(negedge clk);
        start      = v.st;
        static_req = v.sr;
        lane_pad   = v.pad;
        hit_clr    = v.clr;
        sb_q.push_back({v.col, v.sa, v.la, v.hp, v.hc});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            exp = sb_q.pop_front();
            check(nm, exp);
        end
    endtask

    initial begin
        //  st sr pad       clr col   sa la        hp hc
        add(0, 0, 5'b00000, 0, 3'd0, 0, 5'b00000, 0, 2'd0); // idle hold
        add(1, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd0); // -> PAINT
        add(0, 0, 5'b00100, 0, 3'd7, 0, 5'b00000, 0, 2'd0); // one sample only
        add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd0);
        add(0, 0, 5'b00100, 0, 3'd7, 0, 5'b00000, 0, 2'd0);
        add(0, 0, 5'b00100, 0, 3'd3, 0, 5'b00100, 1, 2'd1); // -> LANE2
        add(0, 0, 5'b00100, 0, 3'd3, 0, 5'b00100, 0, 2'd1);
        add(0, 0, 5'b01000, 0, 3'd7, 0, 5'b00000, 0, 2'd1); // other lane -> PAINT
        add(0, 0, 5'b01000, 0, 3'd7, 0, 5'b00000, 0, 2'd1);
        add(0, 0, 5'b01000, 0, 3'd4, 0, 5'b01000, 1, 2'd2); // -> LANE3
        add(0, 1, 5'b00001, 0, 3'd7, 0, 5'b00000, 0, 2'd2); // static_req leaves LANE
        add(0, 1, 5'b00001, 0, 3'd6, 1, 5'b00000, 0, 2'd2); // -> STATIC
        add(0, 1, 5'b00100, 0, 3'd6, 1, 5'b00000, 0, 2'd2); // onehot keeps STATIC
        add(0, 1, 5'b00011, 0, 3'd7, 0, 5'b00000, 0, 2'd2); // multi-hot -> PAINT
        add(0, 0, 5'b00011, 0, 3'd7, 0, 5'b00000, 0, 2'd2); // multi-hot stays
        for (int i = 0; i < 7; i++)
            add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd2);
        add(1, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd2); // start resets timeout
        for (int i = 0; i < 7; i++)
            add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd2);
        add(0, 0, 5'b00000, 0, 3'd0, 0, 5'b00000, 0, 2'd2); // 8th quiet -> IDLE
        add(1, 0, 5'b00001, 0, 3'd0, 0, 5'b00000, 0, 2'd2); // start with pad: stay
        add(1, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd2);
        add(0, 0, 5'b00001, 0, 3'd7, 0, 5'b00000, 0, 2'd2);
        add(0, 0, 5'b00001, 0, 3'd1, 0, 5'b00001, 1, 2'd3); // LANE0, count 3
        add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd3);
        add(0, 0, 5'b00010, 0, 3'd7, 0, 5'b00000, 0, 2'd3);
        add(0, 0, 5'b00010, 0, 3'd2, 0, 5'b00010, 1, 2'd3); // saturated, pulse fires
        add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd3);
        add(0, 0, 5'b10000, 0, 3'd7, 0, 5'b00000, 0, 2'd3);
        add(0, 0, 5'b10000, 1, 3'd5, 0, 5'b10000, 1, 2'd0); // clear wins on entry
        add(0, 0, 5'b10000, 0, 3'd5, 0, 5'b10000, 0, 2'd0);
        add(0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd0);
        add(0, 0, 5'b00100, 0, 3'd7, 0, 5'b00000, 0, 2'd0);
        add(0, 0, 5'b00100, 0, 3'd3, 0, 5'b00100, 1, 2'd1);
        add(0, 0, 5'b00100, 1, 3'd3, 0, 5'b00100, 0, 2'd0); // clear outside entry

        #1;
        check("reset_state", 12'h000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("row%0d", i), tbl[i]);

        // Re-enter LANE2, then hit reset mid-cycle while the pulse is high.
        apply("re_paint", '{0, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd0});
        apply("re_deb",   '{0, 0, 5'b00100, 0, 3'd7, 0, 5'b00000, 0, 2'd0});
        apply("re_lane",  '{0, 0, 5'b00100, 0, 3'd3, 0, 5'b00100, 1, 2'd1});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 12'h000);
        @(negedge clk);
        reset = 1'b0;
        apply("post_reset_idle",  '{0, 0, 5'b00000, 0, 3'd0, 0, 5'b00000, 0, 2'd0});
        apply("post_reset_paint", '{1, 0, 5'b00000, 0, 3'd7, 0, 5'b00000, 0, 2'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
